// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the per-axis phase encoding.
package vga_timing_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_t;

endpackage

// File: rtl/vga_phase_counter.sv
// One timing axis: wrapping position counter, phase FSM and registered active-low sync.
// The sync level is decoded from the next phase so it lines up with the count it belongs to.
module vga_phase_counter
   import vga_timing_pkg::*;
#(
   parameter int ACT = 640,
   parameter int FP  = 16,
   parameter int SW  = 96,
   parameter int BP  = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] count,
   output logic [1:0] phase_dbg,
   output logic       wrap,
   output logic       next_active,
   output logic       sync_n
);

   localparam logic [9:0] ACT_END = 10'(ACT - 1);
   localparam logic [9:0] FP_END  = 10'(ACT + FP - 1);
   localparam logic [9:0] SW_END  = 10'(ACT + FP + SW - 1);
   localparam logic [9:0] LAST    = 10'(ACT + FP + SW + BP - 1);

   logic [9:0] count_q, count_d;
   phase_t     phase_q, phase_d;
   logic       sync_n_q, sync_n_d;

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (en) begin
         if (count_q == LAST) count_d = '0;
         else                 count_d = count_q + 10'd1;
         // Phase steps when the count sits on the last value of the current phase.
         case (phase_q)
            ACTIVE:  if (count_q == ACT_END) phase_d = FRONT;
            FRONT:   if (count_q == FP_END)  phase_d = SYNC;
            SYNC:    if (count_q == SW_END)  phase_d = BACK;
            BACK:    if (count_q == LAST)    phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
      sync_n_d = (phase_d != SYNC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         phase_q  <= ACTIVE;
         sync_n_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         phase_q  <= phase_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign count       = count_q;
   assign phase_dbg   = phase_q;
   assign wrap        = (count_q == LAST);
   assign next_active = (phase_d == ACTIVE);
   assign sync_n      = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing generator with pix_en-qualified advance and registered sync/blank/pulses.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
   import vga_timing_pkg::*;
(
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        frame_start,
   output logic        line_start,
`ifdef VGA_FRAME_COUNT_EN
   output logic [15:0] frame_count,
`endif
   output logic [1:0]  h_phase_dbg,
   output logic [1:0]  v_phase_dbg
);

   logic h_wrap, v_wrap, h_next_active, v_next_active, v_en;
   logic blank_q, blank_d;
   logic frame_start_q, frame_start_d;
   logic line_start_q, line_start_d;

   // The vertical axis only moves on the edge that wraps the horizontal one.
   assign v_en = pix_en & h_wrap;

   vga_phase_counter #(
      .ACT(H_ACTIVE), .FP(H_FRONT), .SW(H_SYNC), .BP(H_BACK)
   ) u_hcnt (
      .clk(vga_clk), .rst(reset), .en(pix_en),
      .count(DrawX), .phase_dbg(h_phase_dbg), .wrap(h_wrap),
      .next_active(h_next_active), .sync_n(hs)
   );

   vga_phase_counter #(
      .ACT(V_ACTIVE), .FP(V_FRONT), .SW(V_SYNC), .BP(V_BACK)
   ) u_vcnt (
      .clk(vga_clk), .rst(reset), .en(v_en),
      .count(DrawY), .phase_dbg(v_phase_dbg), .wrap(v_wrap),
      .next_active(v_next_active), .sync_n(vs)
   );

   always_comb begin
      blank_d       = pix_en ? (h_next_active & v_next_active) : blank_q;
      frame_start_d = pix_en & h_wrap & v_wrap;
      line_start_d  = pix_en & h_wrap;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   // Bumps on the same edge that raises frame_start; natural 16-bit rollover.
   always_comb begin
      frame_count_d = frame_count_q;
      if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) frame_count_q <= '0;
      else       frame_count_q <= frame_count_d;
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; long idle stretches are skipped by forcing the counters.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic [9:0]  DrawX, DrawY;
   logic        hs, vs, blank, frame_start, line_start;
   logic [1:0]  h_phase_dbg, v_phase_dbg;
`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   vga_timing_gen dut (
      .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
      .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank(blank),
      .frame_start(frame_start), .line_start(line_start),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count(frame_count),
`endif
      .h_phase_dbg(h_phase_dbg), .v_phase_dbg(v_phase_dbg)
   );

   // ---------------- clock / reset ----------------
   always #20 vga_clk = ~vga_clk;

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge vga_clk);
      @(negedge vga_clk);
      cyc++;
   endtask

   function automatic phase_t phase_of(input int c, input int a, input int f, input int s);
      if (c < a)         return ACTIVE;
      if (c < a + f)     return FRONT;
      if (c < a + f + s) return SYNC;
      return BACK;
   endfunction

   logic [9:0] jx, jy;
   phase_t     jhp, jvp;

   // Called on a falling edge: loads a counter position so the next edge advances from it.
   task jump(input int x, input int y);
      jx  = 10'(x);
      jy  = 10'(y);
      jhp = phase_of(x, H_ACTIVE, H_FRONT, H_SYNC);
      jvp = phase_of(y, V_ACTIVE, V_FRONT, V_SYNC);
      force dut.u_hcnt.count_q = jx;
      force dut.u_hcnt.phase_q = jhp;
      force dut.u_vcnt.count_q = jy;
      force dut.u_vcnt.phase_q = jvp;
      #1;
      release dut.u_hcnt.count_q;
      release dut.u_hcnt.phase_q;
      release dut.u_vcnt.count_q;
      release dut.u_vcnt.phase_q;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_x"}, 32'(DrawX), 0);
      check({pfx, "_y"}, 32'(DrawY), 0);
      check({pfx, "_hs"}, 32'(hs), 1);
      check({pfx, "_vs"}, 32'(vs), 1);
      check({pfx, "_blank"}, 32'(blank), 0);
      check({pfx, "_fs"}, 32'(frame_start), 0);
      check({pfx, "_ls"}, 32'(line_start), 0);
      check({pfx, "_hph"}, 32'(h_phase_dbg), 0);
      check({pfx, "_vph"}, 32'(v_phase_dbg), 0);
   endtask

   // ---------------- stimulus ----------------
   int mark, cnt;

   initial begin
      reset  = 1'b1;
      pix_en = 1'b1;
      repeat (5) @(negedge vga_clk);
      check_reset_vals("rst");

      // First enabled edge after release
      reset = 1'b0;
      step();
      check("rel_x", 32'(DrawX), 1);
      check("rel_y", 32'(DrawY), 0);
      check("rel_blank", 32'(blank), 1);
      check("rel_hs", 32'(hs), 1);

      // Horizontal sync position and width, line length
      mark = cyc;
      while (hs !== 1'b0 && cyc - mark < 2000) step();
      check("hs_fall_x", 32'(DrawX), 656);
      check("hs_fall_cyc", 32'(cyc - mark), 655);
      check("hs_phase", 32'(h_phase_dbg), 32'(SYNC));
      check("hs_blank", 32'(blank), 0);
      cnt = 0;
      while (hs === 1'b0 && cnt < 2000) begin step(); cnt++; end
      check("hs_low_len", 32'(cnt), 96);
      check("hs_rise_x", 32'(DrawX), 752);
      while (line_start !== 1'b1 && cyc - mark < 2000) step();
      check("line_len", 32'(cyc - mark), 799);
      check("line_x", 32'(DrawX), 0);
      check("line_y", 32'(DrawY), 1);
      check("line_blank", 32'(blank), 1);
      check("line_fs", 32'(frame_start), 0);
      step();
      check("line_ls_off", 32'(line_start), 0);
      check("line_x1", 32'(DrawX), 1);

      // Vertical sync position and width
      jump(799, 489);
      step();
      check("vs_fall_x", 32'(DrawX), 0);
      check("vs_fall_y", 32'(DrawY), 490);
      check("vs_fall", 32'(vs), 0);
      check("vs_blank", 32'(blank), 0);
      cnt = 0;
      while (vs === 1'b0 && cnt < 4000) begin step(); cnt++; end
      check("vs_low_len", 32'(cnt), 1600);
      check("vs_rise_y", 32'(DrawY), 492);
      check("vs_rise_x", 32'(DrawX), 0);

      // Frame wrap
      jump(799, 524);
      step();
      check("wrap_x", 32'(DrawX), 0);
      check("wrap_y", 32'(DrawY), 0);
      check("wrap_fs", 32'(frame_start), 1);
      check("wrap_ls", 32'(line_start), 1);
      check("wrap_blank", 32'(blank), 1);
      check("wrap_vs", 32'(vs), 1);
      step();
      check("wrap_fs_off", 32'(frame_start), 0);
      check("wrap_x1", 32'(DrawX), 1);

      // Half-rate enable: line period doubles, pulses stay one clock
      jump(799, 0);
      step();
      check("tog_ls0", 32'(line_start), 1);
      mark = cyc;
      cnt = 0;
      do begin
         pix_en = ~pix_en;
         step();
      end while (line_start !== 1'b1 && cyc - mark < 4000);
      check("tog_period", 32'(cyc - mark), 1600);
      pix_en = 1'b0;
      step();
      check("tog_ls_off", 32'(line_start), 0);
      check("tog_x_hold", 32'(DrawX), 0);
      jump(799, 524);
      pix_en = 1'b1;
      step();
      check("tog_fs_on", 32'(frame_start), 1);
      pix_en = 1'b0;
      step();
      check("tog_fs_off", 32'(frame_start), 0);
      check("tog_ls_off2", 32'(line_start), 0);
      check("tog_blank_hold", 32'(blank), 1);

      // Hold mid hsync with enable low
      jump(700, 100);
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      repeat (20) step();
      check("hold_x", 32'(DrawX), 701);
      check("hold_y", 32'(DrawY), 100);
      check("hold_hs", 32'(hs), 0);
      check("hold_vs", 32'(vs), 1);
      check("hold_blank", 32'(blank), 0);

      // Asynchronous reset between edges
      pix_en = 1'b1;
      jump(699, 300);
      step();
      check("pre_rst_x", 32'(DrawX), 700);
      check("pre_rst_hs", 32'(hs), 0);
      #5 reset = 1'b1;
      #1;
      check_reset_vals("arst");
      @(negedge vga_clk);
      reset = 1'b0;
      step();
      check("arst_rel_x", 32'(DrawX), 1);

`ifdef VGA_FRAME_COUNT_EN
      check("fc_init", 32'(frame_count), 0);
      for (int i = 0; i < 3; i++) begin
         jump(799, 524);
         step();
      end
      check("fc_three", 32'(frame_count), 3);
      force dut.frame_count_q = 16'hffff;
      #1;
      release dut.frame_count_q;
      jump(799, 524);
      step();
      check("fc_wrap", 32'(frame_count), 0);
      check("fc_wrap_fs", 32'(frame_start), 1);
`endif

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset domain.
REQ-002 Port vga_clk, input, 1: pixel clock, 25 MHz nominal; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high.
REQ-004 Port pix_en, input, 1: pixel-advance enable; when low, all state and outputs hold.
REQ-005 Port DrawX, output, 10: current horizontal count, 0..799.
REQ-006 Port DrawY, output, 10: current vertical count, 0..524.
REQ-007 Port hs, output, 1: horizontal sync, active-low.
REQ-008 Port vs, output, 1: vertical sync, active-low.
REQ-009 Port blank, output, 1: high = visible pixel (DrawX<640 and DrawY<480), low = blanking.
REQ-010 Port frame_start, output, 1: one-cycle pulse when the count becomes (0,0).
REQ-011 Port line_start, output, 1: one-cycle pulse when DrawX becomes 0.

Function
REQ-012 Horizontal timing SHALL be 640 active, 16 front porch, 96 sync, 48 back porch (800 total); vertical SHALL be 480, 10, 2, 33 (525 total).
REQ-013 Each counter SHALL track phase with a four-state machine ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, advancing when the count reaches the phase end.
REQ-014 On each rising edge with pix_en high, DrawX SHALL increment; at 799 it SHALL wrap to 0 and DrawY SHALL increment; at (799,524) both SHALL wrap to (0,0).
REQ-015 hs, vs, blank, frame_start and line_start SHALL be registered, decoded from the next count, and valid on the same cycle as the matching DrawX/DrawY (zero relative latency).
REQ-016 hs SHALL be low exactly for DrawX 656..751; vs SHALL be low exactly for DrawY 490..491.
REQ-017 frame_start and line_start SHALL pulse for exactly one pix_en-qualified cycle; with pix_en low on the following edge they SHALL deassert, never repeating the event.
REQ-018 Counter arithmetic SHALL be 10-bit unsigned with explicit compare-and-wrap; no modulo operators.
REQ-019 With pix_en held low indefinitely, outputs SHALL remain constant, including sync levels mid-pulse.

Reset
REQ-020 While reset is high: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, line_start=0, both phase FSMs=ACTIVE.
REQ-021 Reset SHALL dominate pix_en; asserting reset mid-frame SHALL force the reset values immediately, without waiting for a clock edge.
REQ-022 The first pix_en-qualified edge after reset release SHALL advance to (1,0) with blank=1; the first frame_start SHALL occur at the first wrap, 420000 enabled cycles after release.

Configuration
REQ-023 Macro VGA_FRAME_COUNT_EN: when defined, add output frame_count, 16 bits, reset 0, incremented on the same edge frame_start rises, wrapping 65535->0.
REQ-024 Without VGA_FRAME_COUNT_EN, the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-025 Package vga_timing_pkg SHALL hold the eight porch/sync/active constants, the totals, and the phase enum typedef (ACTIVE, FRONT, SYNC, BACK).
REQ-026 Sub-module vga_phase_counter (count, phase FSM, wrap flag, sync decode), parameterised by the four phase lengths, SHALL be instantiated twice: horizontal, and vertical with the horizontal wrap flag as its enable.

Verification
REQ-027 Reset held 5 cycles, pix_en=1 -> all outputs at reset values; release -> after 1 edge DrawX=1, DrawY=0, blank=1.
REQ-028 Free-run 2 frames -> 800 clocks per line, 525 lines per frame; hs low 96 clocks starting at DrawX=656; vs low 1600 clocks starting at DrawY=490, DrawX=0.
REQ-029 Count at (799,524) -> next edge gives (0,0), frame_start=1, line_start=1, blank=1; the following edge gives frame_start=0.
REQ-030 pix_en toggled 1/0 every cycle -> line period 1600 clocks; each frame_start/line_start high for exactly 1 clock.
REQ-031 Reset asserted at DrawX=700, DrawY=300 between edges -> outputs return to reset values before the next edge.
REQ-032 With VGA_FRAME_COUNT_EN, run 3 frames -> frame_count reads 3; force 65535 -> next frame_start gives 0.
